// File: rtl/key_debounce_pkg.sv
// Shared constants for the multi-channel key debouncer: default debounce and
// long-press cycle counts for a 50 MHz system clock.
package key_debounce_pkg;

  localparam int unsigned CNT_20MS_50M = 32'd999_999;
  localparam int unsigned CNT_1S_50M   = 32'd49_999_999;

endpackage

// File: rtl/key_debounce_ch.sv
// One key channel: 2-flop synchronizer, stable-count debouncer with press/release
// pulses, and (when KEY_LONG_PRESS_EN is defined) a long-press detector.
module key_debounce_ch
  import key_debounce_pkg::*;
#(
  parameter int unsigned CNT_MAX    = CNT_20MS_50M,
  parameter int unsigned LONG_MAX   = CNT_1S_50M,
  parameter bit          ACTIVE_LOW = 1'b1
) (
  input  logic sys_clk,
  input  logic sys_rst_n,
  input  logic key_in,
  output logic key_state,
  output logic press_flag,
  output logic release_flag,
  output logic long_flag
);

  localparam int unsigned          CNT_W    = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0]     CNT_LAST = CNT_W'(CNT_MAX);
  localparam logic                 RELEASED = ACTIVE_LOW;

  if (LONG_MAX <= CNT_MAX) begin : g_bad_long_max
    $error("key_debounce_ch: LONG_MAX must be greater than CNT_MAX");
  end

  logic             sync1_q, sync1_d;
  logic             sync2_q, sync2_d;
  logic             key_sync;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             state_q, state_d;
  logic             press_q, press_d;
  logic             release_q, release_d;

  assign key_sync = ACTIVE_LOW ? ~sync2_q : sync2_q;

  // Any cycle where the synchronized level agrees with the debounced state
  // restarts the count, so only an unbroken run of CNT_MAX+1 mismatches toggles.
  always_comb begin
    sync1_d   = key_in;
    sync2_d   = sync1_q;
    cnt_d     = '0;
    state_d   = state_q;
    press_d   = 1'b0;
    release_d = 1'b0;
    if (key_sync != state_q) begin
      if (cnt_q == CNT_LAST) begin
        state_d   = ~state_q;
        press_d   = ~state_q;
        release_d = state_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      sync1_q   <= RELEASED;
      sync2_q   <= RELEASED;
      cnt_q     <= '0;
      state_q   <= 1'b0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
    end else begin
      sync1_q   <= sync1_d;
      sync2_q   <= sync2_d;
      cnt_q     <= cnt_d;
      state_q   <= state_d;
      press_q   <= press_d;
      release_q <= release_d;
    end
  end

  assign key_state    = state_q;
  assign press_flag   = press_q;
  assign release_flag = release_q;

`ifdef KEY_LONG_PRESS_EN
  localparam int unsigned           LONG_W    = $clog2(LONG_MAX + 1);
  localparam logic [LONG_W-1:0]     LONG_LAST = LONG_W'(LONG_MAX);

  logic [LONG_W-1:0] lcnt_q, lcnt_d;
  logic              ldone_q, ldone_d;
  logic              long_q, long_d;

  // The counter parks at LONG_LAST; ldone_q keeps the pulse to one per press.
  always_comb begin
    lcnt_d  = lcnt_q;
    ldone_d = ldone_q;
    long_d  = 1'b0;
    if (!state_d) begin
      lcnt_d  = '0;
      ldone_d = 1'b0;
    end else if (state_q) begin
      if (lcnt_q != LONG_LAST) begin
        lcnt_d = lcnt_q + 1'b1;
      end else if (!ldone_q) begin
        long_d  = 1'b1;
        ldone_d = 1'b1;
      end
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      lcnt_q  <= '0;
      ldone_q <= 1'b0;
      long_q  <= 1'b0;
    end else begin
      lcnt_q  <= lcnt_d;
      ldone_q <= ldone_d;
      long_q  <= long_d;
    end
  end

  assign long_flag = long_q;
`else
  assign long_flag = 1'b0;
`endif

endmodule

// File: rtl/key_debounce_multi.sv
// KEY_NUM independent debounced key channels. Define KEY_LONG_PRESS_EN to build
// the long-press detectors; otherwise long_flag is held at 0.
module key_debounce_multi
  import key_debounce_pkg::*;
#(
  parameter int unsigned KEY_NUM    = 4,
  parameter int unsigned CNT_MAX    = CNT_20MS_50M,
  parameter int unsigned LONG_MAX   = CNT_1S_50M,
  parameter bit          ACTIVE_LOW = 1'b1
) (
  input  logic               sys_clk,
  input  logic               sys_rst_n,
  input  logic [KEY_NUM-1:0] key_in,
  output logic [KEY_NUM-1:0] key_state,
  output logic [KEY_NUM-1:0] press_flag,
  output logic [KEY_NUM-1:0] release_flag,
  output logic [KEY_NUM-1:0] long_flag
);

  for (genvar i = 0; i < KEY_NUM; i++) begin : g_ch
    key_debounce_ch #(
      .CNT_MAX    (CNT_MAX),
      .LONG_MAX   (LONG_MAX),
      .ACTIVE_LOW (ACTIVE_LOW)
    ) u_ch (
      .sys_clk      (sys_clk),
      .sys_rst_n    (sys_rst_n),
      .key_in       (key_in[i]),
      .key_state    (key_state[i]),
      .press_flag   (press_flag[i]),
      .release_flag (release_flag[i]),
      .long_flag    (long_flag[i])
    );
  end

endmodule

// File: tb/tb_key_debounce_multi.sv
// Scoreboard bench for key_debounce_multi: a run-length reference model pushes
// expected flag events, a negedge monitor pops and compares them.
module tb_key_debounce_multi;

  localparam int KN = 4;
  localparam int CM = 15;
  localparam int LM = 63;
`ifdef KEY_LONG_PRESS_EN
  localparam bit LONG_EN = 1'b1;
`else
  localparam bit LONG_EN = 1'b0;
`endif

  logic          sys_clk   = 1'b0;
  logic          sys_rst_n = 1'b1;
  logic [KN-1:0] key_in    = '1;
  logic [KN-1:0] key_state, press_flag, release_flag, long_flag;

  key_debounce_multi #(
    .KEY_NUM    (KN),
    .CNT_MAX    (CM),
    .LONG_MAX   (LM),
    .ACTIVE_LOW (1'b1)
  ) dut (
    .sys_clk      (sys_clk),
    .sys_rst_n    (sys_rst_n),
    .key_in       (key_in),
    .key_state    (key_state),
    .press_flag   (press_flag),
    .release_flag (release_flag),
    .long_flag    (long_flag)
  );

  always #5 sys_clk = ~sys_clk;

  typedef struct {
    int unsigned   cyc;
    logic [KN-1:0] pr;
    logic [KN-1:0] rl;
    logic [KN-1:0] lg;
    logic [KN-1:0] st;
  } ev_t;

  ev_t exp_q[$];
  int  checks = 0;
  int  errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Reference model: a channel's level flips once the pressed level seen two
  // edges late has disagreed with it for CM+1 edges in a row; a long press is
  // reported LM+1 edges after the press edge if the key is still down.
  int unsigned   cyc = 0;
  logic [KN-1:0] m_state = '0;
  logic [KN-1:0] d1 = '0, d2 = '0, samp;
  int            run [KN];
  int unsigned   press_at [KN];
  ev_t           ev;

  always @(posedge sys_clk) begin
    cyc++;
    if (!sys_rst_n) begin
      m_state = '0;
      d1 = '0;
      d2 = '0;
      for (int c = 0; c < KN; c++) run[c] = 0;
    end else begin
      samp = d2;
      d2   = d1;
      d1   = ~key_in;
      ev.cyc = cyc;
      ev.pr = '0;
      ev.rl = '0;
      ev.lg = '0;
      for (int c = 0; c < KN; c++) begin
        if (samp[c] != m_state[c]) run[c]++;
        else run[c] = 0;
        if (run[c] == CM + 1) begin
          run[c] = 0;
          m_state[c] = ~m_state[c];
          if (m_state[c]) begin
            ev.pr[c] = 1'b1;
            press_at[c] = cyc;
          end else begin
            ev.rl[c] = 1'b1;
          end
        end else if (LONG_EN && m_state[c] && cyc == press_at[c] + LM + 1) begin
          ev.lg[c] = 1'b1;
        end
      end
      ev.st = m_state;
      if ((ev.pr | ev.rl | ev.lg) != '0) exp_q.push_back(ev);
    end
  end

  ev_t mon_e;

  always @(negedge sys_clk) begin
    if (!sys_rst_n) begin
      chk("reset_outputs", 32'({key_state, press_flag, release_flag, long_flag}), 32'd0);
    end else if ((press_flag | release_flag | long_flag) != '0) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_flag", 32'({press_flag, release_flag, long_flag}), 32'd0);
      end else begin
        mon_e = exp_q.pop_front();
        chk("event_cycle", cyc, mon_e.cyc);
        chk("press_flag", 32'(press_flag), 32'(mon_e.pr));
        chk("release_flag", 32'(release_flag), 32'(mon_e.rl));
        chk("long_flag", 32'(long_flag), 32'(mon_e.lg));
        chk("key_state", 32'(key_state), 32'(mon_e.st));
      end
    end else if (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
      mon_e = exp_q.pop_front();
      chk("missing_flag", 32'd0, 32'({mon_e.pr, mon_e.rl, mon_e.lg}));
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge sys_clk);
    #1;
  endtask

  task automatic do_reset(input int n);
    @(negedge sys_clk);
    #1 sys_rst_n = 1'b0;
    repeat (n) @(negedge sys_clk);
    #1 sys_rst_n = 1'b1;
  endtask

  int hold [KN];
  int r;

  initial begin
    #2 sys_rst_n = 1'b0;
    repeat (4) @(negedge sys_clk);
    #1 sys_rst_n = 1'b1;
    tick(5);

    // Single clean press on channel 0.
    key_in[0] = 1'b0;
    tick(30);
    key_in[0] = 1'b1;
    tick(30);

    // Bouncing channel 1: five short lows, then a solid hold.
    for (int p = 0; p < 5; p++) begin
      key_in[1] = 1'b0;
      tick(10);
      key_in[1] = 1'b1;
      tick(3);
    end
    key_in[1] = 1'b0;
    tick(30);
    key_in[1] = 1'b1;
    tick(30);

    // Long press on channel 2, then release.
    key_in[2] = 1'b0;
    tick(100);
    key_in[2] = 1'b1;
    tick(40);

    // All channels pressed on the same edge.
    key_in = '0;
    tick(30);
    key_in = '1;
    tick(30);

    // Reset partway through the debounce count; key stays down across it.
    key_in[0] = 1'b0;
    tick(12);
    do_reset(3);
    tick(30);
    key_in[0] = 1'b1;
    tick(30);

    // Randomized bouncy/held traffic on all channels with one mid-run reset.
    for (int c = 0; c < KN; c++) hold[c] = 0;
    for (int n = 0; n < 3000; n++) begin
      for (int c = 0; c < KN; c++) begin
        if (hold[c] == 0) begin
          key_in[c] = ~key_in[c];
          r = int'($urandom_range(0, 9));
          if (r < 6) hold[c] = int'($urandom_range(1, 14));
          else if (r < 9) hold[c] = int'($urandom_range(16, 40));
          else hold[c] = int'($urandom_range(70, 120));
        end else begin
          hold[c]--;
        end
      end
      if (n == 1500) do_reset(2);
      tick(1);
    end

    key_in = '1;
    tick(40);
    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    chk("final_key_state", 32'(key_state), 32'(m_state));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/key_debounce_multi.md
KEY_DEBOUNCE_MULTI -- requirements
Module: key_debounce_multi

Interface
REQ-001 SHALL have parameter KEY_NUM, default 4: number of independent key channels (1..16).
REQ-002 SHALL have parameter CNT_MAX, default 20'd999_999: stable-cycle count for a valid edge (20 ms at 50 MHz).
REQ-003 SHALL have parameter LONG_MAX, default 26'd49_999_999: pressed-cycle count for a long press (1 s at 50 MHz); legal only if LONG_MAX > CNT_MAX.
REQ-004 SHALL have parameter ACTIVE_LOW, default 1: 1 = key_in low means pressed; 0 = high means pressed.
REQ-005 SHALL have port sys_clk, input, 1 bit: single system clock, all logic on rising edge.
REQ-006 SHALL have port sys_rst_n, input, 1 bit: reset, asynchronous assert, active-low.
REQ-007 SHALL have port key_in, input, KEY_NUM bits: raw asynchronous key levels, one bit per channel.
REQ-008 SHALL have port key_state, output, KEY_NUM bits: debounced level per channel, 1 = pressed.
REQ-009 SHALL have port press_flag, output, KEY_NUM bits: one-cycle pulse on debounced press.
REQ-010 SHALL have port release_flag, output, KEY_NUM bits: one-cycle pulse on debounced release.
REQ-011 SHALL have port long_flag, output, KEY_NUM bits: one-cycle pulse when a press has been held LONG_MAX cycles.

Function
REQ-012 SHALL pass each key_in bit through a 2-flop synchronizer, then normalise polarity per ACTIVE_LOW to key_sync (1 = pressed).
REQ-013 SHALL keep a per-channel counter, width $clog2(CNT_MAX+1), incremented each cycle key_sync != key_state and cleared in any cycle key_sync == key_state (a glitch of any length below threshold restarts the count).
REQ-014 SHALL, on the edge where counter == CNT_MAX and mismatch persists, toggle key_state, clear the counter, and register press_flag (new state 1) or release_flag (new state 0) high for exactly one cycle.
REQ-015 Latency: flag high in the cycle following edge CNT_MAX+2, counting the first edge that samples the new stable raw level as edge 0.
REQ-016 SHALL never assert press_flag and release_flag of one channel in the same cycle; channels are fully independent, simultaneous events on different channels all flag in the same cycle.
REQ-017 Long press: per-channel counter, width $clog2(LONG_MAX+1), counts while key_state == 1, saturates at LONG_MAX; long_flag pulses once on the edge it reaches LONG_MAX; no repeat until release and new press.
REQ-018 Long counter SHALL clear in the cycle key_state falls; release after long press still produces release_flag.
REQ-019 Counters SHALL never wrap; debounce counter saturates logically via REQ-014 clear.

Reset
REQ-020 On sys_rst_n low, SHALL asynchronously set synchronizer flops to the released level, all counters to 0, key_state, press_flag, release_flag, long_flag to 0.
REQ-021 SHALL emit no flag in the first CNT_MAX+2 cycles after reset release, regardless of key_in; a key held through reset is reported as a press CNT_MAX+2 edges after release.
REQ-022 Reset mid-count or mid-long-press SHALL discard progress with no flag.

Configuration
REQ-023 Macro KEY_LONG_PRESS_EN: defined -> long counters and long_flag behave per REQ-017/018; undefined -> long counters absent, long_flag tied to 0, port retained.

Structure
REQ-024 Package key_debounce_pkg SHALL hold constants CNT_20MS_50M (999_999) and CNT_1S_50M (49_999_999) used as parameter defaults.
REQ-025 SHALL instantiate sub-module key_debounce_ch (one channel: sync, debounce, long counter) KEY_NUM times via generate; top contains no other logic.

Verification (bench uses CNT_MAX=15, LONG_MAX=63, KEY_NUM=4, ACTIVE_LOW=1)
REQ-026 key_in[0] 1->0 held -> press_flag[0] one cycle high after edge 17, key_state[0]=1; other channels silent.
REQ-027 key_in[1] low pulses of 10 cycles separated by 3 high cycles, 5 times -> no flag; then held low -> press_flag[1] 17 edges after final fall.
REQ-028 key_in[2] held low 100 cycles -> press_flag then long_flag exactly 64 edges after key_state rise, once; release -> release_flag, no second long_flag.
REQ-029 key_in[3:0]=4'b0000 same edge -> press_flag=4'b1111 in the same single cycle.
REQ-030 sys_rst_n pulsed low at count 10 on channel 0 -> all outputs 0, no flag; key still low -> press_flag 17 edges after reset release.
REQ-031 Build without KEY_LONG_PRESS_EN, repeat REQ-028 -> long_flag stays 0, press/release unchanged.
